// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 1-to-NUM_PORTS packet router: the control FSM
// state encoding, default port/address sizing and small state-class helpers.
// Imported by router_fsm, the register datapath and the write synchronizer.
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int NUM_PORTS_DEF = 3;
    localparam int ADDR_W_DEF    = 2;

    // All eight 3-bit codes are assigned, so every code has a defined meaning.
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    // States in which a byte is pushed into the selected FIFO.
    function automatic logic is_write_state(input state_t st);
        logic wr_s;
        case (st)
            LOAD_FIRST_DATA,
            LOAD_DATA,
            LOAD_PARITY,
            LOAD_AFTER_FULL: wr_s = 1'b1;
            default:         wr_s = 1'b0;
        endcase
        return wr_s;
    endfunction

    // The input port may only present a new byte while decoding a header or
    // streaming payload; every other state stalls it.
    function automatic logic is_busy_state(input state_t st);
        logic busy_s;
        case (st)
            DECODE_ADDRESS,
            LOAD_DATA: busy_s = 1'b0;
            default:   busy_s = 1'b1;
        endcase
        return busy_s;
    endfunction

endpackage : router_pkg

// File: rtl/router_fsm.sv
// -----------------------------------------------------------------------------
// router_fsm
// Control FSM of the 1-to-NUM_PORTS packet router. Decodes the header address,
// sequences the byte-register/parity datapath through one-hot state strobes,
// stalls on a full destination FIFO and waits for an occupied one to drain.
//
// Ports
//   clock, resetn          : rising-edge clock, asynchronous active-low reset
//   pkt_valid              : high for header/payload bytes, low on parity byte
//   data_in                : address bits of the header byte
//   fifo_full/fifo_empty   : per-destination FIFO status
//   soft_reset             : per-destination timeout reset (selected port only)
//   parity_done            : parity byte captured by the datapath
//   low_pkt_valid          : datapath has latched end-of-packet
//   detect_add .. rst_int_reg : state strobes for the datapath
//   write_enb_reg          : write strobe to the selected FIFO
//   busy                   : input-side stall
//   dest_sel               : one-hot latched destination (zero while decoding)
//   sel_full               : full flag of the latched destination
// -----------------------------------------------------------------------------
module router_fsm
    import router_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] dest_sel,
    output logic                 sel_full
);

    // One extra bit so the comparison also works when NUM_PORTS == 2**ADDR_W.
    localparam logic [ADDR_W:0] PORT_LIMIT = (ADDR_W+1)'(NUM_PORTS);

    // Select one per-port flag by a (possibly out-of-range) address; an
    // out-of-range address reads as 0 instead of indexing past the vector.
    function automatic logic pick_bit(input logic [NUM_PORTS-1:0] vec,
                                      input logic [ADDR_W-1:0]    idx);
        logic sel_bit_s;
        sel_bit_s = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (idx == ADDR_W'(i)) begin
                sel_bit_s = vec[i];
            end else begin
                sel_bit_s = sel_bit_s;
            end
        end
        return sel_bit_s;
    endfunction

    function automatic logic [NUM_PORTS-1:0] one_hot(input logic [ADDR_W-1:0] idx);
        logic [NUM_PORTS-1:0] vec_s;
        vec_s = {NUM_PORTS{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (idx == ADDR_W'(i)) begin
                vec_s[i] = 1'b1;
            end else begin
                vec_s[i] = 1'b0;
            end
        end
        return vec_s;
    endfunction

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_next;
    logic                w_addr_valid;
    logic                w_in_empty;
    logic                w_f;
    logic                w_e;
    logic                w_s;

    assign w_addr_valid = ({1'b0, data_in} < PORT_LIMIT);
    // While decoding, emptiness is judged on the incoming header's port.
    assign w_in_empty   = pick_bit(fifo_empty, data_in);
    assign w_f          = pick_bit(fifo_full,  r_addr);
    assign w_e          = pick_bit(fifo_empty, r_addr);
    assign w_s          = pick_bit(soft_reset, r_addr);

    // Next-state and address-latch decision.
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        // A timeout on the latched port aborts the packet from any active
        // state and overrides every other condition, including fifo_full.
        if ((r_state != DECODE_ADDRESS) && w_s) begin
            w_state_next = DECODE_ADDRESS;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (pkt_valid && w_addr_valid) begin
                        w_addr_next = data_in;
                        if (w_in_empty) begin
                            w_state_next = LOAD_FIRST_DATA;
                        end else begin
                            w_state_next = WAIT_TILL_EMPTY;
                        end
                    end else begin
                        // Invalid address or idle line: packet dropped.
                        w_state_next = DECODE_ADDRESS;
                    end
                end
                LOAD_FIRST_DATA: begin
                    w_state_next = LOAD_DATA;
                end
                LOAD_DATA: begin
                    if (w_f) begin
                        w_state_next = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        w_state_next = LOAD_PARITY;
                    end else begin
                        w_state_next = LOAD_DATA;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (w_f) begin
                        w_state_next = FIFO_FULL_STATE;
                    end else begin
                        w_state_next = LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        w_state_next = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        w_state_next = LOAD_PARITY;
                    end else begin
                        w_state_next = LOAD_DATA;
                    end
                end
                LOAD_PARITY: begin
                    w_state_next = CHECK_PARITY_ERROR;
                end
                CHECK_PARITY_ERROR: begin
                    if (w_f) begin
                        w_state_next = FIFO_FULL_STATE;
                    end else begin
                        w_state_next = DECODE_ADDRESS;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (w_e) begin
                        w_state_next = LOAD_FIRST_DATA;
                    end else begin
                        w_state_next = WAIT_TILL_EMPTY;
                    end
                end
                default: begin
                    w_state_next = DECODE_ADDRESS;
                end
            endcase
        end
    end

    // State register and latched destination address.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= DECODE_ADDRESS;
            r_addr  <= {ADDR_W{1'b0}};
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
        end
    end

    // Moore strobes registered from the next state, so each output is a
    // glitch-free flop whose value always equals a decode of r_state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            rst_int_reg   <= 1'b0;
            write_enb_reg <= 1'b0;
            busy          <= 1'b0;
            dest_sel      <= {NUM_PORTS{1'b0}};
        end else begin
            detect_add    <= (w_state_next == DECODE_ADDRESS);
            lfd_state     <= (w_state_next == LOAD_FIRST_DATA);
            ld_state      <= (w_state_next == LOAD_DATA);
            laf_state     <= (w_state_next == LOAD_AFTER_FULL);
            full_state    <= (w_state_next == FIFO_FULL_STATE);
            rst_int_reg   <= (w_state_next == CHECK_PARITY_ERROR);
            write_enb_reg <= is_write_state(w_state_next);
            busy          <= is_busy_state(w_state_next);
            if (w_state_next == DECODE_ADDRESS) begin
                dest_sel <= {NUM_PORTS{1'b0}};
            end else begin
                dest_sel <= one_hot(w_addr_next);
            end
        end
    end

    // sel_full must follow fifo_full within the cycle, so it stays combinational.
    assign sel_full = (r_state != DECODE_ADDRESS) ? w_f : 1'b0;

endmodule : router_fsm

// File: tb/tb_router_fsm.sv
module tb_router_fsm;

    localparam int NP = 3;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic       write_enb_reg, busy, sel_full;
    logic [2:0] dest_sel;

    router_fsm #(.NUM_PORTS(3), .ADDR_W(2)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy), .dest_sel(dest_sel),
        .sel_full(sel_full)
    );

    always #5 clock = ~clock;

    // Reference model: packet phases, independent of the RTL encoding.
    typedef enum int {P_IDLE, P_FIRST, P_DATA, P_FULL, P_AFTER, P_PAR, P_CHK, P_WAIT} phase_t;
    phase_t m_ph   = P_IDLE;
    int     m_addr = 0;

    logic [11:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [11:0] expect_vec();
        logic       we, bz, sf;
        logic [2:0] ds;
        we = (m_ph == P_FIRST) || (m_ph == P_DATA) || (m_ph == P_PAR) || (m_ph == P_AFTER);
        bz = !((m_ph == P_IDLE) || (m_ph == P_DATA));
        ds = (m_ph == P_IDLE) ? 3'b000 : 3'(1 << m_addr);
        sf = (m_ph != P_IDLE) && fifo_full[m_addr];
        return {m_ph == P_IDLE, m_ph == P_FIRST, m_ph == P_DATA, m_ph == P_AFTER,
                m_ph == P_FULL, m_ph == P_CHK, we, bz, ds, sf};
    endfunction

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_step();
        phase_t nx;
        int     a;
        if (!resetn) begin
            m_ph   = P_IDLE;
            m_addr = 0;
        end else begin
            a  = m_addr;
            nx = m_ph;
            if (m_ph != P_IDLE && soft_reset[a]) begin
                nx = P_IDLE;
            end else begin
                case (m_ph)
                    P_IDLE:  if (pkt_valid && int'(data_in) < NP) begin
                                 m_addr = int'(data_in);
                                 nx = fifo_empty[data_in] ? P_FIRST : P_WAIT;
                             end
                    P_FIRST: nx = P_DATA;
                    P_DATA:  nx = fifo_full[a] ? P_FULL : (!pkt_valid ? P_PAR : P_DATA);
                    P_FULL:  nx = fifo_full[a] ? P_FULL : P_AFTER;
                    P_AFTER: nx = parity_done ? P_IDLE : (low_pkt_valid ? P_PAR : P_DATA);
                    P_PAR:   nx = P_CHK;
                    P_CHK:   nx = fifo_full[a] ? P_FULL : P_IDLE;
                    P_WAIT:  nx = fifo_empty[a] ? P_FIRST : P_WAIT;
                    default: nx = P_IDLE;
                endcase
            end
            m_ph = nx;
        end
    endtask

    // Entered at posedge+2: inputs are applied, expectation queued, edge taken.
    task automatic step(input logic v, input logic [1:0] d, input logic [2:0] f,
                        input logic [2:0] e, input logic [2:0] s,
                        input logic p, input logic l);
        pkt_valid = v; data_in = d; fifo_full = f; fifo_empty = e;
        soft_reset = s; parity_done = p; low_pkt_valid = l;
        model_step();
        exp_q.push_back(expect_vec());
        @(posedge clock);
        #2;
    endtask

    // Monitor: compares the DUT against the queued expectation after each edge.
    initial begin
        logic [11:0] exp_v, act_v;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
                         write_enb_reg, busy, dest_sel, sel_full};
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL outs t=%0t got=%b want=%b (da lfd ld laf full rst we busy sel[2:0] sf)",
                             $time, act_v, exp_v);
                end
            end
        end
    end

    initial begin
        resetn = 1'b0;
        pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 3'b000; fifo_empty = 3'b111;
        soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
        @(posedge clock);
        #2;
        // Reset state
        step(1'b0, 2'd0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        step(1'b0, 2'd0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        resetn = 1'b1;
        // Header addr 1 (0x0D), 3 payload bytes, parity
        step(1'b1, 2'd1, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        // Addr 2 busy destination, drains at cycle 4
        for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 3'b000, 3'b011, 3'b000, 1'b0, 1'b0);
        step(1'b1, 2'd2, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        step(1'b1, 2'd2, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd2, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        // FIFO full for 3 cycles, then LOAD_AFTER_FULL with each exit condition
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'd0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
            step(1'b1, 2'd0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 3'b001, 3'b111, 3'b000, 1'b0, 1'b0);
            step(1'b1, 2'd0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
            step(1'b1, 2'd0, 3'b000, 3'b111, 3'b000, k == 2, k == 1);
            for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        end
        // Invalid address 3 is dropped
        for (int i = 0; i < 3; i++) step(1'b1, 2'd3, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        // One-byte payload
        step(1'b1, 2'd2, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        step(1'b1, 2'd2, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd2, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        // Soft reset: other port ignored, own port aborts
        step(1'b1, 2'd1, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        step(1'b1, 2'd1, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        step(1'b1, 2'd1, 3'b000, 3'b111, 3'b001, 1'b0, 1'b0);
        step(1'b1, 2'd1, 3'b000, 3'b111, 3'b010, 1'b0, 1'b0);
        step(1'b0, 2'd1, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        // Soft reset together with fifo_full: soft reset wins
        step(1'b1, 2'd1, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        step(1'b1, 2'd1, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        step(1'b1, 2'd1, 3'b010, 3'b111, 3'b010, 1'b0, 1'b0);
        step(1'b0, 2'd1, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        // Mid-cycle asynchronous reset while in LOAD_DATA
        step(1'b1, 2'd1, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        step(1'b1, 2'd1, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        total++;
        if (detect_add !== 1'b1 || ld_state !== 1'b0 || write_enb_reg !== 1'b0 || dest_sel !== 3'b000) begin
            bad++;
            $display("FAIL async_reset got da=%b ld=%b we=%b sel=%b want da=1 ld=0 we=0 sel=000",
                     detect_add, ld_state, write_enb_reg, dest_sel);
        end
        m_ph = P_IDLE;
        m_addr = 0;
        @(posedge clock);
        #2;
        step(1'b1, 2'd1, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0);
        resetn = 1'b1;
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            resetn = ($urandom_range(0, 199) != 0);
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 {$urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0},
                 3'($urandom_range(0, 7)),
                 {$urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0},
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_router_fsm

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control FSM for the 1-to-NUM_PORTS packet router.
- Decodes the header address and sequences the byte-register/parity datapath. It does this through the state-strobe outputs: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg.
- Handles back-pressure from the selected destination FIFO and waits for an occupied destination FIFO to drain.
- Sits between the input port, the write synchronizer/FIFOs and the register datapath.

Parameters:
- NUM_PORTS, 3, number of destination FIFOs; valid header addresses are 0..NUM_PORTS-1.
- ADDR_W, 2, header address field width; address taken from data_in[ADDR_W-1:0].

Ports:
- clock  in  1  system clock; state register updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- pkt_valid  in  1  high while header/payload bytes are presented; low on the parity byte.
- data_in  in  ADDR_W  address bits of the header byte.
- fifo_full  in  NUM_PORTS  per-destination FIFO full flags.
- fifo_empty  in  NUM_PORTS  per-destination FIFO empty flags.
- soft_reset  in  NUM_PORTS  per-destination timeout soft reset.
- parity_done  in  1  parity byte captured by datapath.
- low_pkt_valid  in  1  datapath latched end-of-packet.
- detect_add  out  1  state == DECODE_ADDRESS.
- lfd_state  out  1  state == LOAD_FIRST_DATA.
- ld_state  out  1  state == LOAD_DATA.
- laf_state  out  1  state == LOAD_AFTER_FULL.
- full_state  out  1  state == FIFO_FULL_STATE.
- rst_int_reg  out  1  state == CHECK_PARITY_ERROR.
- write_enb_reg  out  1  write strobe to the selected FIFO.
- busy  out  1  input-side stall.
- dest_sel  out  NUM_PORTS  one-hot latched destination; all-zero in DECODE_ADDRESS.
- sel_full  out  1  fifo_full[latched addr]; 0 in DECODE_ADDRESS.

Behaviour:
- Reset
  - resetn low (asynchronous) forces state = DECODE_ADDRESS and addr_q = 0.
  - Resulting output values: detect_add = 1, all other outputs 0.
- Address latch
  - addr_q <= data_in on any rising edge in DECODE_ADDRESS with pkt_valid = 1 and data_in < NUM_PORTS.
  - Otherwise addr_q holds.
- Derived signals
  - f = fifo_full[addr_q], e = fifo_empty[addr_q], s = soft_reset[addr_q].
  - In DECODE_ADDRESS, the empty check uses fifo_empty[data_in].
- Transitions, evaluated every rising edge
  - Priority 1: s = 1 in any state other than DECODE_ADDRESS -> DECODE_ADDRESS.
  - DECODE_ADDRESS:
    - pkt_valid and addr valid and fifo_empty[data_in] -> LOAD_FIRST_DATA.
    - pkt_valid and addr valid and not empty -> WAIT_TILL_EMPTY.
    - Invalid address (data_in >= NUM_PORTS) or !pkt_valid -> stay; the packet is dropped.
  - LOAD_FIRST_DATA -> LOAD_DATA, unconditional.
  - LOAD_DATA:
    - f -> FIFO_FULL_STATE.
    - else !pkt_valid -> LOAD_PARITY.
    - else stay.
  - FIFO_FULL_STATE: !f -> LOAD_AFTER_FULL, else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - else low_pkt_valid -> LOAD_PARITY.
    - else LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: f -> FIFO_FULL_STATE, else DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: e -> LOAD_FIRST_DATA, else stay.
  - Unused encodings -> DECODE_ADDRESS.
- Outputs are Moore (decoded from the state register only), except sel_full.
  - write_enb_reg = 1 in LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Timing
  - Outputs are stable for the full clock period; the register datapath samples them on the following falling edge.
- Boundary conditions
  - Simultaneous soft_reset and fifo_full: soft_reset wins.
  - soft_reset for a non-selected port is ignored.
  - Reset mid-packet: immediate return to DECODE_ADDRESS; remaining bytes of the in-flight packet are not written.
  - One-byte-payload packets, i.e. pkt_valid falling in LOAD_DATA on its first cycle, are legal.

Decomposition:
- Package router_pkg:
  - state_t enum (8 states, 3-bit encoding).
  - NUM_PORTS_DEF, ADDR_W_DEF.
  - Shared with router_reg and the synchronizer.
- Single module; no sub-module warranted.
  - Next-state logic is one combinational block.
  - State register and addr_q register are one sequential block.

Test Plan:
- Reset, then header 0x0D (addr 1) with pkt_valid = 1 and fifo_empty = 3'b111 -> states LFD, then LD.
  - 3 payload bytes, then pkt_valid = 0 -> LOAD_PARITY, CHECK_PARITY_ERROR, DECODE_ADDRESS.
  - write_enb_reg high for 5 cycles; dest_sel = 3'b010 throughout.
- Header addr 2 with fifo_empty[2] = 0 -> WAIT_TILL_EMPTY, busy = 1.
  - Set fifo_empty[2] = 1 at cycle 4 -> LOAD_FIRST_DATA on the next edge.
- In LOAD_DATA, raise fifo_full[0] for 3 cycles -> FIFO_FULL_STATE for 3 cycles (full_state = 1, busy = 1, write_enb_reg = 0), then LOAD_AFTER_FULL.
  - With low_pkt_valid = 0 and parity_done = 0 -> LOAD_DATA.
- Same as the previous case but low_pkt_valid = 1 in LOAD_AFTER_FULL -> LOAD_PARITY.
  - With parity_done = 1 instead -> DECODE_ADDRESS.
- Header addr 3 (invalid) with pkt_valid = 1 -> remains DECODE_ADDRESS; dest_sel = 0; no write_enb_reg.
- In LOAD_DATA to port 1:
  - Pulse soft_reset[0] -> no effect.
  - Pulse soft_reset[1] -> DECODE_ADDRESS on the next edge.
  - Assert resetn = 0 mid-cycle -> detect_add = 1 asynchronously, before the next clock edge.
